// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and constants for the hazard controller
package pipeline_ctrl_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;
    localparam int MEM_TIMEOUT_DEFAULT = 16;
    localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/load_use_detector.sv
// load_use_detector: flags a load in EX whose destination feeds the instruction in ID
// Ports: rs/rt (ID sources), mem_read (EX is a load), dest (EX destination), hazard (out).
module load_use_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       mem_read,
    input  logic [4:0] dest,
    output logic       hazard
);
    // Register zero is hardwired, so a load targeting it never creates a dependency.
    assign hazard = mem_read && dest != REG_ZERO && (dest == rs || dest == rt);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for memory waits, load-use hazards and taken branches
// Ports: clk/reset; ID/EX hazard operands; branch and MEM-stage access qualifiers; memReadyInput;
//        per-stage write enables and flushes, memory request, sticky fault, frozen-PC cycle count.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             ifIdRsInput,
    input  logic [4:0]             ifIdRtInput,
    input  logic                   idExMemReadInput,
    input  logic [4:0]             idExRegWriteAddressInput,
    input  logic                   branchTakenInput,
    input  logic                   exMemMemReadInput,
    input  logic                   exMemMemWriteInput,
    input  logic                   memReadyInput,
    output logic                   pcWriteEnableOutput,
    output logic                   ifIdWriteEnableOutput,
    output logic                   ifIdFlushOutput,
    output logic                   idExWriteEnableOutput,
    output logic                   idExFlushOutput,
    output logic                   exMemWriteEnableOutput,
    output logic                   memWbFlushOutput,
    output logic                   memRequestOutput,
    output logic                   faultOutput,
    output logic [STALL_CNT_W-1:0] stallCountOutput
);
    state_t                 state;
    logic [7:0]             wait_cnt;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   mem_access;
    logic                   freeze;
    logic                   hazard;
    logic                   load_use;

    load_use_detector u_lud (
        .rs       (ifIdRsInput),
        .rt       (ifIdRtInput),
        .mem_read (idExMemReadInput),
        .dest     (idExRegWriteAddressInput),
        .hazard   (hazard)
    );

    always_comb begin
        mem_access = exMemMemReadInput || exMemMemWriteInput;
        // A pending wait freezes on !ready even if the access qualifiers drop.
        freeze     = state == FAULT || (!memReadyInput && (state == MEM_WAIT || mem_access));
        load_use   = !freeze && hazard;
    end

    assign pcWriteEnableOutput    = !freeze && !load_use;
    assign ifIdWriteEnableOutput  = !freeze && !load_use;
    assign idExWriteEnableOutput  = !freeze;
    assign exMemWriteEnableOutput = !freeze;
    assign idExFlushOutput        = load_use;
    // A branch masked by any stall is simply seen again on the next cycle.
    assign ifIdFlushOutput        = branchTakenInput && !freeze && !load_use;
    assign memWbFlushOutput       = freeze;
    assign memRequestOutput       = mem_access && state != FAULT;
    assign faultOutput            = state == FAULT;
    assign stallCountOutput       = stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            stall_cnt <= '0;
        end else begin
            if (state != FAULT && !pcWriteEnableOutput && stall_cnt != '1)
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            case (state)
                RUN: if (mem_access && !memReadyInput) begin
                    state    <= MEM_WAIT;
                    wait_cnt <= 8'd1;
                end
                MEM_WAIT: if (memReadyInput) begin
                    state    <= RUN;
                    wait_cnt <= 8'd0;
                end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
                    state    <= FAULT;
                    wait_cnt <= 8'd0;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                default: state <= FAULT;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of the hazard controller against a cycle model
module tb_pipeline_hazard_ctrl;
    localparam int TMO = 4;
    localparam int CW  = 4;

    logic          clk = 0;
    logic          reset = 1;
    logic [4:0]    rs = 0, rt = 0, dest = 0;
    logic          ld_ex = 0, br = 0, rd = 0, wr = 0, rdy = 1;
    logic          pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_we, memwb_fl, mem_req, fault;
    logic [CW-1:0] stall_cnt;

    int  vectors = 0;
    int  miscompares = 0;
    bit  faulted = 0;
    int  waited = 0;
    int  stalls = 0;
    bit  exp_adv;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .STALL_CNT_W(CW)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .ifIdRsInput              (rs),
        .ifIdRtInput              (rt),
        .idExMemReadInput         (ld_ex),
        .idExRegWriteAddressInput (dest),
        .branchTakenInput         (br),
        .exMemMemReadInput        (rd),
        .exMemMemWriteInput       (wr),
        .memReadyInput            (rdy),
        .pcWriteEnableOutput      (pc_we),
        .ifIdWriteEnableOutput    (ifid_we),
        .ifIdFlushOutput          (ifid_fl),
        .idExWriteEnableOutput    (idex_we),
        .idExFlushOutput          (idex_fl),
        .exMemWriteEnableOutput   (exmem_we),
        .memWbFlushOutput         (memwb_fl),
        .memRequestOutput         (mem_req),
        .faultOutput              (fault),
        .stallCountOutput         (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs come straight from the rules: faults and unanswered accesses freeze
    // everything, otherwise a load-use dependency holds PC/IF-ID, otherwise a branch flushes.
    task automatic check_outputs();
        bit access = rd || wr;
        bit frozen = faulted || (!rdy && (waited > 0 || access));
        bit lu     = !frozen && ld_ex && dest != 0 && (dest == rs || dest == rt);
        exp_adv = !frozen && !lu;
        chk("pcWrite",   pc_we,    exp_adv);
        chk("ifIdWrite", ifid_we,  exp_adv);
        chk("idExWrite", idex_we,  !frozen);
        chk("exMemWrite", exmem_we, !frozen);
        chk("ifIdFlush", ifid_fl,  br && exp_adv);
        chk("idExFlush", idex_fl,  lu);
        chk("memWbFlush", memwb_fl, frozen);
        chk("memReq",    mem_req,  access && !faulted);
        chk("fault",     fault,    faulted);
        chk("stallCnt",  stall_cnt, stalls);
    endtask

    task automatic model_update();
        bit access = rd || wr;
        if (reset) begin
            faulted = 0;
            waited  = 0;
            stalls  = 0;
        end else if (!faulted) begin
            if (!exp_adv) stalls = stalls < (1 << CW) - 1 ? stalls + 1 : (1 << CW) - 1;
            if (waited == 0) begin
                if (access && !rdy) waited = 1;
            end else if (rdy) waited = 0;
            else if (waited == TMO) begin
                faulted = 1;
                waited  = 0;
            end else waited++;
        end
    endtask

    task automatic tick();
        #1;
        vectors++;
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(input logic [4:0] s, input logic [4:0] t, input logic l, input logic [4:0] d,
                        input logic b, input logic r, input logic w, input logic y, input logic x);
        rs = s; rt = t; ld_ex = l; dest = d; br = b; rd = r; wr = w; rdy = y; reset = x;
        tick();
    endtask

    initial begin
        reset = 1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        // idle after reset
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("rst_stall", stall_cnt, 0);
        // load-use on rs, then dest = r0 never stalls
        step(8, 3, 1, 8, 0, 0, 0, 1, 0);
        step(8, 3, 0, 8, 0, 0, 0, 1, 0);
        chk("lu_cnt", stall_cnt, 1);
        step(0, 0, 1, 0, 0, 0, 0, 1, 0);
        step(2, 9, 1, 9, 0, 0, 0, 1, 0);
        // branch flush with no stall
        step(1, 2, 0, 0, 1, 0, 0, 1, 0);
        // zero-wait read
        step(0, 0, 0, 0, 0, 1, 0, 1, 0);
        chk("zw_cnt", stall_cnt, 2);
        // store waits three cycles
        repeat (3) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("w3_cnt", stall_cnt, 5);
        // memory wait + load-use + branch together: freeze only
        step(4, 4, 1, 4, 1, 1, 0, 0, 0);
        step(4, 4, 1, 4, 1, 1, 0, 0, 0);
        step(4, 4, 1, 4, 1, 1, 0, 1, 0);
        // timeout: five frozen cycles then FAULT
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        repeat (5) step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("to_fault", fault, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1, 0);
        chk("to_sticky", fault, 1);
        step(0, 0, 0, 0, 0, 1, 0, 1, 1);
        chk("to_rst_fault", fault, 0);
        chk("to_rst_cnt", stall_cnt, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        // saturation
        repeat (20) step(7, 0, 1, 7, 0, 0, 0, 1, 0);
        chk("sat", stall_cnt, 4'hF);
        // randomized traffic with small register numbers to provoke collisions
        for (int i = 0; i < 600; i++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), faulted ? $urandom_range(0, 7) == 0 : $urandom_range(0, 63) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max MEM_WAIT cycles before fault (range 2..255).
REQ-002 SHALL have parameter STALL_CNT_W, default 16, width of stall counter.
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports clk and reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ifIdRsInput  input  5  rs of instruction in ID.
REQ-007 ifIdRtInput  input  5  rt of instruction in ID.
REQ-008 idExMemReadInput  input  1  instruction in EX is a load.
REQ-009 idExRegWriteAddressInput  input  5  destination register of instruction in EX.
REQ-010 branchTakenInput  input  1  branch resolved taken in ID.
REQ-011 exMemMemReadInput  input  1  MEM stage load.
REQ-012 exMemMemWriteInput  input  1  MEM stage store.
REQ-013 memReadyInput  input  1  data memory completes current access this cycle.
REQ-014 pcWriteEnableOutput  output  1  PC update enable.
REQ-015 ifIdWriteEnableOutput  output  1  IF/ID load enable.
REQ-016 ifIdFlushOutput  output  1  IF/ID clear to bubble.
REQ-017 idExWriteEnableOutput  output  1  ID/EX load enable.
REQ-018 idExFlushOutput  output  1  ID/EX clear to bubble.
REQ-019 exMemWriteEnableOutput  output  1  EX/MEM load enable.
REQ-020 memWbFlushOutput  output  1  MEM/WB clear to bubble.
REQ-021 memRequestOutput  output  1  data memory access request.
REQ-022 faultOutput  output  1  sticky memory timeout fault.
REQ-023 stallCountOutput  output  STALL_CNT_W  cycles with PC frozen.

Function
REQ-024 SHALL implement FSM states RUN, MEM_WAIT, FAULT; default outputs: all write enables 1, flushes 0, fault 0.
REQ-025 memRequestOutput SHALL equal (exMemMemReadInput | exMemMemWriteInput) in RUN and MEM_WAIT, 0 in FAULT.
REQ-026 RUN with memory access and memReadyInput=1: zero-wait, no stall, stay RUN.
REQ-027 RUN with memory access and memReadyInput=0: all four write enables 0, memWbFlushOutput=1, next state MEM_WAIT, wait counter loaded 1.
REQ-028 MEM_WAIT with memReadyInput=0: same freeze outputs as REQ-027, wait counter increments.
REQ-029 MEM_WAIT with memReadyInput=1: enables 1, memWbFlush 0 (access completes), next state RUN, counter cleared.
REQ-030 MEM_WAIT with counter = MEM_TIMEOUT and memReadyInput=0: next state FAULT; ready on that same cycle wins (RUN).
REQ-031 FAULT: all enables 0, memWbFlush 1, faultOutput 1, exit only by reset.
REQ-032 Load-use (RUN, no memory stall): idExMemReadInput=1, idExRegWriteAddressInput != 0, equal to ifIdRsInput or ifIdRtInput -> pcWrite 0, ifIdWrite 0, idExFlush 1, one cycle per occurrence.
REQ-033 Priority: memory stall/FAULT > load-use > branch flush.
REQ-034 branchTakenInput SHALL assert ifIdFlushOutput only when no stall of any kind; a suppressed branch re-evaluates next cycle.
REQ-035 stallCountOutput SHALL increment each cycle pcWriteEnableOutput=0 outside FAULT, saturating at all-ones.
REQ-036 Control outputs SHALL be combinational from state and inputs; state, wait counter and stall counter are registered.

Reset
REQ-037 reset SHALL force state RUN, wait counter 0, stallCountOutput 0, fault cleared, taking priority over every other event including ready or timeout in the same cycle.
REQ-038 After reset with idle inputs: enables 1, flushes 0, memRequest 0, fault 0.

Structure
REQ-039 Package pipeline_ctrl_pkg SHALL hold the state enum, MEM_TIMEOUT default, and REG_ZERO constant (5'd0).
REQ-040 Sub-module load_use_detector (combinational, REQ-032 comparison) SHALL be the only instantiated child.

Verification
REQ-041 Load-use: idExMemRead=1, dest=5'd8, rs=8 -> one cycle pcWrite=0, ifIdWrite=0, idExFlush=1; dest=0, rs=0 -> no stall.
REQ-042 Zero-wait: exMemMemRead=1, memReady=1 -> no freeze, stallCount unchanged.
REQ-043 Wait 3: exMemMemWrite=1, memReady low 3 cycles then high -> 3 freeze cycles, memWbFlush=1 each, stallCount=3, RUN after.
REQ-044 Timeout: MEM_TIMEOUT=4, memReady held 0 -> FAULT after 5th cycle, faultOutput=1, memRequest=0; reset -> RUN, fault 0, stallCount 0.
REQ-045 Priority: memory wait + load-use + branchTaken same cycle -> freeze only, ifIdFlush=0, idExFlush=0.
REQ-046 Saturation: STALL_CNT_W=4, 20 stall cycles -> stallCountOutput=4'hF.
